// File: rtl/eth_rx_buf.sv
// eth_rx_buf: two-bank receive frame buffer behind the RMII MAC receiver.
// Frames are written into a free bank as the bytes arrive and committed only
// if the FCS, error, length and destination-address checks pass. Committed
// frames are read at random by the consumer and released with frm_done.
// Optional feature: define ETH_RX_MAC_FILTER_EN to accept only frames whose
// DA is MAC_ADDR or broadcast; otherwise the buffer is promiscuous.
//
// state   | meaning
// SYNC    | after reset, wait for the MAC to go idle (skip in-flight frame)
// IDLE    | wait for byte 0 of a new frame
// RECV    | storing bytes into bank wb
// CHECK   | one cycle: decide commit or drop
// DISCARD | ignore bytes until the frame ends
module eth_rx_buf #(
    parameter logic [47:0] MAC_ADDR = 48'h02_00_00_00_00_01,
    parameter int          MIN_LEN  = 64,
    parameter int          MAX_LEN  = 1518
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_vld,
    input  logic        in_last,
    input  logic        in_err,
    input  logic        in_crc_ok,
    input  logic        in_busy,
    input  logic [10:0] in_addr,
    input  logic [7:0]  in_data,
    output logic        frm_vld,
    output logic [10:0] frm_len,
    input  logic [10:0] rd_addr,
    output logic [7:0]  rd_data,
    input  logic        frm_done,
    output logic [15:0] cnt_ok,
    output logic [15:0] cnt_drop
);

    typedef enum logic [2:0] {SYNC, IDLE, RECV, CHECK, DISCARD} state_t;

    localparam logic [10:0] MAX_LEN_W = 11'(MAX_LEN);
    localparam logic [11:0] MIN_LEN_W = 12'(MIN_LEN);

    state_t      state, state_nx;
    logic [7:0]  mem [0:4095];
    logic [1:0]  full;
    logic [10:0] len_q [2];
    logic        wb, rb;
    logic [10:0] last_addr;
    logic        oversize;
    logic        mac_ok;
    logic        wr_en, start, cap_last, commit, drop;
    logic        accept, release_rd;

    // Length is checked on last_addr+1 in 12 bits so 2047+1 cannot wrap.
    assign accept     = in_crc_ok & ~in_err & ~oversize & mac_ok &
                        (({1'b0, last_addr} + 12'd1) >= MIN_LEN_W);
    assign release_rd = frm_done & full[rb];
    assign frm_vld    = full[rb];
    assign frm_len    = len_q[rb];

    // Writer state register.
    always_ff @(posedge clk) begin
        if (reset) state <= SYNC;
        else       state <= state_nx;
    end

    // Writer next-state and control strobes.
    always_comb begin
        state_nx = state;
        wr_en    = 1'b0;
        start    = 1'b0;
        cap_last = 1'b0;
        commit   = 1'b0;
        drop     = 1'b0;
        case (state)
            SYNC: if (!in_busy) state_nx = IDLE;
            IDLE: begin
                if (in_vld) begin
                    if (in_addr == 11'd0) begin
                        if (!full[wb]) begin
                            wr_en    = 1'b1;
                            start    = 1'b1;
                            state_nx = RECV;
                        end else begin
                            drop     = 1'b1;
                            state_nx = DISCARD;
                        end
                    end else begin
                        state_nx = DISCARD;
                    end
                end
            end
            RECV: begin
                if (in_vld) begin
                    wr_en = 1'b1;
                    if (in_last) begin
                        cap_last = 1'b1;
                        state_nx = CHECK;
                    end
                end else if (!in_busy) begin
                    drop     = 1'b1;
                    state_nx = IDLE;
                end
            end
            CHECK: begin
                if (accept) commit = 1'b1;
                else        drop   = 1'b1;
                state_nx = IDLE;
            end
            DISCARD: begin
                if ((in_vld && in_last) || (!in_vld && !in_busy)) state_nx = IDLE;
            end
            default: state_nx = SYNC;
        endcase
    end

    // Per-frame bookkeeping: oversize flag and final byte index.
    always_ff @(posedge clk) begin
        if (reset) begin
            oversize  <= 1'b0;
            last_addr <= '0;
        end else begin
            if (start)
                oversize <= 1'b0;
            else if (state == RECV && in_vld && in_addr >= MAX_LEN_W)
                oversize <= 1'b1;
            if (cap_last) last_addr <= in_addr;
        end
    end

`ifdef ETH_RX_MAC_FILTER_EN
    logic       uni_ok, bc_ok;
    logic [7:0] mac_byte;

    // Station address byte expected at the current DA position.
    always_comb begin
        mac_byte = 8'h00;
        case (in_addr[2:0])
            3'd0:    mac_byte = MAC_ADDR[47:40];
            3'd1:    mac_byte = MAC_ADDR[39:32];
            3'd2:    mac_byte = MAC_ADDR[31:24];
            3'd3:    mac_byte = MAC_ADDR[23:16];
            3'd4:    mac_byte = MAC_ADDR[15:8];
            3'd5:    mac_byte = MAC_ADDR[7:0];
            default: mac_byte = 8'h00;
        endcase
    end

    // Running DA match against the station address and broadcast.
    always_ff @(posedge clk) begin
        if (reset) begin
            uni_ok <= 1'b0;
            bc_ok  <= 1'b0;
        end else if (start) begin
            uni_ok <= (in_data == MAC_ADDR[47:40]);
            bc_ok  <= (in_data == 8'hFF);
        end else if (state == RECV && in_vld && in_addr < 11'd6) begin
            uni_ok <= uni_ok & (in_data == mac_byte);
            bc_ok  <= bc_ok & (in_data == 8'hFF);
        end
    end

    assign mac_ok = uni_ok | bc_ok;
`else
    assign mac_ok = 1'b1;
`endif

    // Byte store into the write bank; the read bank is never the write bank.
    always_ff @(posedge clk) begin
        if (wr_en) mem[{wb, in_addr}] <= in_data;
    end

    // Registered random-access read of the current frame.
    always_ff @(posedge clk) begin
        if (reset) rd_data <= 8'h00;
        else       rd_data <= mem[{rb, rd_addr}];
    end

    // Bank ownership: commit fills bank wb, release frees bank rb.
    always_ff @(posedge clk) begin
        if (reset) begin
            full     <= 2'b00;
            len_q[0] <= '0;
            len_q[1] <= '0;
            wb       <= 1'b0;
            rb       <= 1'b0;
        end else begin
            if (commit) begin
                full[wb]  <= 1'b1;
                len_q[wb] <= last_addr - 11'd3;
                wb        <= ~wb;
            end
            if (release_rd) begin
                full[rb] <= 1'b0;
                rb       <= ~rb;
            end
        end
    end

    // Saturating frame statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_ok   <= '0;
            cnt_drop <= '0;
        end else begin
            if (commit && cnt_ok != 16'hFFFF)   cnt_ok   <= cnt_ok + 16'd1;
            if (drop   && cnt_drop != 16'hFFFF) cnt_drop <= cnt_drop + 16'd1;
        end
    end

endmodule

// File: tb/tb_eth_rx_buf.sv
// tb_eth_rx_buf: directed frames into eth_rx_buf; expected frames are queued
// at send time and a monitor compares each presented frame against the queue.
module tb_eth_rx_buf;

    localparam logic [47:0] MAC  = 48'h02_00_00_00_00_01;
    localparam logic [47:0] OTH  = 48'h02_00_00_00_00_02;
    localparam logic [47:0] BCST = 48'hFF_FF_FF_FF_FF_FF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_vld = 1'b0, in_last = 1'b0, in_err = 1'b0, in_crc_ok = 1'b0, in_busy = 1'b0;
    logic [10:0] in_addr = '0;
    logic [7:0]  in_data = '0;
    logic        frm_vld;
    logic [10:0] frm_len;
    logic [10:0] rd_addr = '0;
    logic [7:0]  rd_data;
    logic        frm_done = 1'b0;
    logic [15:0] cnt_ok, cnt_drop;

    typedef struct {
        int          len;
        logic [47:0] da;
        logic [7:0]  seed;
    } frm_t;

    frm_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   hold     = 1'b0;
    bit   mon_busy = 1'b0;
    int   exp_ok   = 0;
    int   exp_drop = 0;

    eth_rx_buf dut (
        .clk      (clk),
        .reset    (reset),
        .in_vld   (in_vld),
        .in_last  (in_last),
        .in_err   (in_err),
        .in_crc_ok(in_crc_ok),
        .in_busy  (in_busy),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .frm_vld  (frm_vld),
        .frm_len  (frm_len),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .frm_done (frm_done),
        .cnt_ok   (cnt_ok),
        .cnt_drop (cnt_drop)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] fb(input logic [47:0] da, input logic [7:0] seed, input int i);
        if (i < 6) return da[47-8*i -: 8];
        return seed + 8'(i);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_cnt_ok"}, int'(cnt_ok), exp_ok);
        chk({tag, "_cnt_drop"}, int'(cnt_drop), exp_drop);
    endtask

    // Sends a full frame; returns on the falling edge of the CHECK cycle.
    task automatic send_frame(input int n, input logic [47:0] da, input logic [7:0] seed,
                              input bit crc, input bit err, input bit exp_commit);
        frm_t e;
        if (exp_commit) begin
            e.len = n; e.da = da; e.seed = seed;
            exp_q.push_back(e);
        end
        @(negedge clk);
        in_busy = 1'b1; in_crc_ok = 1'b0; in_err = 1'b0;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            in_vld  = 1'b1;
            in_addr = 11'(i);
            in_data = fb(da, seed, i);
            in_last = (i == n - 1);
            if (err && i == n / 2) in_err = 1'b1;
            if (i == n - 1) in_crc_ok = crc;
            @(negedge clk);
            in_vld = 1'b0; in_last = 1'b0;
            if (i == n - 1) in_busy = 1'b0;
            else @(negedge clk);
        end
    endtask

    // Sends bytes first..last-1 of a frame without ending it; MAC stays busy.
    task automatic send_bytes(input int first, input int last, input bit with_end);
        in_busy = 1'b1;
        for (int i = first; i < last; i++) begin
            @(negedge clk);
            in_vld  = 1'b1;
            in_addr = 11'(i);
            in_data = fb(MAC, 8'h77, i);
            in_last = with_end && (i == last - 1);
            in_crc_ok = with_end && (i == last - 1);
            @(negedge clk);
            in_vld = 1'b0; in_last = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while ((exp_q.size() != 0 || mon_busy || frm_vld) && t < 20000) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (t >= 20000) begin
            n_fail++;
            $display("FAIL %s_drain: timeout with %0d frames pending", tag, exp_q.size());
        end
    endtask

    // Monitor: every presented frame is read back and compared with the queue head.
    initial begin
        frm_t e;
        int   bad, first_bad;
        logic [7:0] want, got_first;
        forever begin
            @(negedge clk);
            if (frm_vld && !hold && !reset) begin
                mon_busy = 1'b1;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_frame: got frame len %0d expected none", frm_len);
                end else begin
                    e = exp_q.pop_front();
                    chk("frm_len", int'(frm_len), e.len - 4);
                    bad = 0; first_bad = -1; got_first = 8'h00;
                    for (int i = 0; i < e.len - 4; i++) begin
                        rd_addr = 11'(i);
                        @(negedge clk);
                        want = fb(e.da, e.seed, i);
                        if (rd_data !== want) begin
                            if (bad == 0) begin first_bad = i; got_first = rd_data; end
                            bad++;
                        end
                    end
                    if (bad != 0)
                        $display("FAIL frm_data_byte: addr %0d got %02h expected %02h",
                                 first_bad, got_first, fb(e.da, e.seed, first_bad));
                    chk("frm_data_errs", bad, 0);
                end
                frm_done = 1'b1;
                @(negedge clk);
                frm_done = 1'b0;
                mon_busy = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_frm_vld", int'(frm_vld), 0);
        chk("rst_frm_len", int'(frm_len), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        chk_counters("rst");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Good 64-byte frame: frm_vld two cycles after in_last
        send_frame(64, MAC, 8'h10, 1'b1, 1'b0, 1'b1);
        chk("t1_vld_plus1", int'(frm_vld), 0);
        @(negedge clk);
        chk("t1_vld_plus2", int'(frm_vld), 1);
        exp_ok = 1;
        chk_counters("t1");
        drain("t1");

        // Bad FCS, then MAC error
        send_frame(64, MAC, 8'h20, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        exp_drop = 1;
        chk("t2_crc_vld", int'(frm_vld), 0);
        chk_counters("t2crc");
        send_frame(64, MAC, 8'h30, 1'b1, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        exp_drop = 2;
        chk("t2_err_vld", int'(frm_vld), 0);
        chk_counters("t2err");

        // Both banks full: third frame dropped, fourth accepted after release
        hold = 1'b1;
        send_frame(64, MAC, 8'h40, 1'b1, 1'b0, 1'b1);
        send_frame(100, MAC, 8'h50, 1'b1, 1'b0, 1'b1);
        send_frame(64, MAC, 8'h60, 1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        exp_ok = 3; exp_drop = 3;
        chk_counters("t3full");
        chk("t3_vld", int'(frm_vld), 1);
        chk("t3_len", int'(frm_len), 60);
        hold = 1'b0;
        drain("t3a");
        send_frame(80, MAC, 8'h70, 1'b1, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        exp_ok = 4;
        chk_counters("t3d");
        drain("t3d");

        // Length boundaries
        send_frame(63, MAC, 8'h80, 1'b1, 1'b0, 1'b0);
        send_frame(1518, MAC, 8'h90, 1'b1, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        chk("t4_1518_len", int'(frm_len), 1514);
        drain("t4");
        send_frame(1519, MAC, 8'hA0, 1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        exp_ok = 5; exp_drop = 5;
        chk_counters("t4");

        // Destination address handling
`ifdef ETH_RX_MAC_FILTER_EN
        send_frame(64, OTH, 8'hB0, 1'b1, 1'b0, 1'b0);
        exp_drop++;
`else
        send_frame(64, OTH, 8'hB0, 1'b1, 1'b0, 1'b1);
        exp_ok++;
`endif
        send_frame(64, BCST, 8'hC0, 1'b1, 1'b0, 1'b1);
        exp_ok++;
        repeat (2) @(negedge clk);
        chk_counters("t5");
        drain("t5");

        // MAC abort mid-frame
        send_bytes(0, 20, 1'b0);
        @(negedge clk);
        in_busy = 1'b0;
        repeat (3) @(negedge clk);
        exp_drop++;
        chk_counters("t6");

        // Reset while a frame is being received
        send_bytes(0, 20, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("t7_rst_vld", int'(frm_vld), 0);
        chk("t7_rst_len", int'(frm_len), 0);
        chk("t7_rst_rd_data", int'(rd_data), 0);
        exp_ok = 0; exp_drop = 0;
        chk_counters("t7rst");
        @(negedge clk);
        reset = 1'b0;
        send_bytes(20, 64, 1'b1);
        @(negedge clk);
        in_busy = 1'b0;
        repeat (3) @(negedge clk);
        chk("t7_inflight_vld", int'(frm_vld), 0);
        chk_counters("t7inflight");
        send_frame(64, MAC, 8'hD0, 1'b1, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        exp_ok = 1;
        chk_counters("t7");
        drain("t7");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_rx_buf.md
# eth_rx_buf

Receive frame buffer placed directly downstream of the RMII MAC receiver. Consumes the MAC's per-byte strobe stream, stores each frame in one of two 2048-byte banks, and commits it only if FCS, error, length and (optionally) destination-address checks pass. Failed frames are dropped. Committed frames are presented to the consumer as a random-access frame with a valid/done handshake.

## Interface
Parameters:
- MAC_ADDR, 48'h02_00_00_00_00_01: station address; byte 0 is the first byte on the wire.
- MIN_LEN, 64: minimum accepted frame length in bytes, FCS included.
- MAX_LEN, 1518: maximum accepted frame length in bytes, FCS included; must be ≤ 2047.

Ports (reset is synchronous, active-high; clock is clk):
- clk  in  1  system clock, 100 MHz
- reset  in  1  synchronous, active-high
- in_vld  in  1  byte strobe from the MAC, one-cycle pulse per byte
- in_last  in  1  coincides with the in_vld pulse of the frame's final byte
- in_err  in  1  sticky frame error from the MAC
- in_crc_ok  in  1  FCS residue check from the MAC
- in_busy  in  1  MAC receiver not idle
- in_addr  in  11  byte index within the frame (0 = first DA byte)
- in_data  in  8  received byte
- frm_vld  out  1  committed frame available at the read bank
- frm_len  out  11  frame length excluding FCS (bytes)
- rd_addr  in  11  read byte address within the current frame
- rd_data  out  8  mem[read bank][rd_addr], one-cycle latency
- frm_done  in  1  pulse: consumer finished; release the read bank
- cnt_ok  out  16  committed frames, saturating
- cnt_drop  out  16  dropped frames (any cause), saturating

## Operation
- Two banks, each 2048×8, plus per-bank full flag and 11-bit length. Write pointer wb and read pointer rb (1 bit each).
- Writer FSM states:
  - SYNC: entered on reset. Go to IDLE once in_busy=0, so a frame already in progress at reset is never captured.
  - IDLE: on in_vld with in_addr=0:
    - if bank wb is free, write the byte and go to RECV;
    - else increment cnt_drop and go to DISCARD.
    - in_vld with in_addr≠0 → DISCARD with no count.
  - RECV: each in_vld writes in_data to mem[wb][in_addr].
    - mac_ok is evaluated over bytes 0–5.
    - oversize is set if in_addr ≥ MAX_LEN.
    - in_vld&in_last → CHECK, capturing last_addr=in_addr.
    - in_busy=0 with in_vld=0 (MAC abort, no last) → cnt_drop++, IDLE.
  - CHECK (exactly one cycle): accept = in_crc_ok & ~in_err & ~oversize & (last_addr+1 ≥ MIN_LEN) & mac_ok.
    - Accept: full[wb]←1, len[wb]←last_addr−3, wb toggles, cnt_ok++.
    - Reject: cnt_drop++.
    - Either way → IDLE.
  - DISCARD: ignore bytes. in_last, or in_busy=0 with in_vld=0 → IDLE.
- Reader: frm_vld = full[rb]; frm_len = len[rb]. frm_done while frm_vld=1 clears full[rb] and toggles rb. frm_done while frm_vld=0 is ignored.
- A commit and a release in the same cycle both take effect.
- Counters saturate at 16'hFFFF.

## Timing
- Reset values: frm_vld=0, frm_len=0, rd_data=0, cnt_ok=0, cnt_drop=0, both banks free, wb=rb=0, FSM in SYNC.
- rd_data is registered: rd_addr presented in cycle n yields data in cycle n+1.
- Commit latency: frm_vld rises 2 cycles after the in_last pulse (CHECK cycle plus flag register).
- Byte writes happen in the same cycle as in_vld. Write and read never target the same bank.
- A new frame may start in the cycle after CHECK. Minimum RMII inter-frame gap far exceeds 1 cycle.
- Reset mid-frame: all stored frames are lost and counters are cleared; the in-flight frame is not captured (SYNC).
- Both banks full: new frames are counted as dropped until frm_done frees a bank. A frame already in RECV is unaffected.

## Configuration
- ETH_RX_MAC_FILTER_EN defined: mac_ok=1 only if DA equals MAC_ADDR or is FF:FF:FF:FF:FF:FF; other unicast and multicast frames are dropped.
- Not defined: promiscuous. mac_ok is constant 1, MAC_ADDR is unused, and no DA comparator is synthesized.

## Test plan
- 64-byte frame to MAC_ADDR, in_crc_ok=1 at CHECK → frm_vld=1 two cycles after in_last, frm_len=60, rd_addr 0..59 returns the sent bytes one cycle later, cnt_ok=1.
- Same frame with in_crc_ok=0 (and, separately, in_err=1) → frm_vld stays 0, cnt_drop=1, bank wb unchanged.
- Three good frames, no frm_done → first two are committed, third gives cnt_drop=1. frm_done → frm_vld stays 1 with the second frame's frm_len. Fourth frame is then accepted.
- Lengths 63, 1518 and 1519 bytes → dropped, committed (frm_len=1514), dropped.
- With ETH_RX_MAC_FILTER_EN: DA=02:00:00:00:00:02 dropped, DA=broadcast accepted. Without the macro, both accepted.
- Assert reset while a frame is mid-RECV → in_busy high keeps the FSM in SYNC. Next complete frame commits with cnt_ok=1, and all outputs read 0 right after reset.
